aes256_decrypt_core: RTL and testbench
======================================

Name: aes256_decrypt_core

Overview:
- Iterative AES-256 decryptor (FIPS-197 inverse cipher), one round per clock.
- A 256-bit key is loaded once and expanded on-chip into 15 round keys.
- Ciphertext blocks are then decrypted one at a time against that key.
- Sits behind a simple valid/ready block interface in the crypto datapath.

Parameters:
- none (Nk=8, Nr=14 fixed)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- kt  in  [0:255]  cipher key; bit 0 is MSB of key byte 0 (FIPS byte order)
- kt_vld  in  1  key valid; key accepted on a clock edge where kt_vld && kt_rdy
- kt_rdy  out  1  core can accept a new key
- ct  in  [0:127]  ciphertext block; bit 0 is MSB of byte 0; state is column-major
- ct_vld  in  1  ciphertext valid; accepted on a clock edge where ct_vld && ct_rdy
- ct_rdy  out  1  core holds an expanded key and is idle
- pt  out  [0:127]  plaintext result
- pt_vld  out  1  one-cycle pulse marking a new pt

Behaviour:
- Reset (async, rst=0) clears everything:
  - FSM to IDLE_NOKEY; kt_rdy=1, ct_rdy=0, pt_vld=0, pt=0.
  - Key-valid flag cleared; round-key store contents are don't-care.
- FSM states: IDLE_NOKEY, EXPAND, IDLE_KEY, DECRYPT.
- Key load:
  - Accepted in IDLE_NOKEY or IDLE_KEY when kt_vld=1. Key words w[0..7] are registered; go to EXPAND.
  - EXPAND generates one word per clock, w[8]..w[59], into a 60x32 round-key store. That is 52 cycles.
  - Word rule, with Rcon[1..7] = 01,02,04,08,10,20,40:
    - i mod 8 = 0: w[i] = w[i-8] ^ SubWord(RotWord(w[i-1])) ^ Rcon[i/8]
    - i mod 8 = 4: w[i] = w[i-8] ^ SubWord(w[i-1])
    - otherwise: w[i] = w[i-8] ^ w[i-1]
  - After w[59] is written, go to IDLE_KEY.
  - kt_rdy=0 and ct_rdy=0 throughout EXPAND.
- Ciphertext accept:
  - Only in IDLE_KEY (ct_rdy=1, kt_rdy=1). ct_vld while ct_rdy=0 is ignored; the block is not queued.
  - If kt_vld and ct_vld are both high in IDLE_KEY, the key wins and the ciphertext is dropped.
- Decrypt:
  - On accept: state <= ct ^ rk14, where rk(r) = w[4r..4r+3]. Go to DECRYPT with round counter r=13.
  - Each DECRYPT clock: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk(r)), then r decrements.
  - Final round r=0 omits InvMixColumns.
  - Exactly 14 DECRYPT cycles. On the final round: pt <= result, pt_vld=1 for exactly one cycle, return to IDLE_KEY.
  - Latency: ct accepted at edge N, pt/pt_vld visible after edge N+14.
  - ct_rdy and kt_rdy are 0 during DECRYPT and high again the cycle pt_vld is high. A new ct may be accepted on the very next edge; the next pt_vld follows 14 edges later.
- pt holds its value until the next result or reset.
- The key stays resident in IDLE_KEY for any number of blocks.
- A new key load invalidates the old key; ct_rdy stays 0 until the new expansion completes.
- Arithmetic:
  - GF(2^8) with polynomial 0x11b.
  - InvMixColumns matrix rows are {0e,0b,0d,09} rotated per row.
  - InvShiftRows rotates row r right by r bytes.
  - InvSbox is the standard FIPS-197 inverse table; the key expansion uses the forward Sbox.
- Reset mid-operation (EXPAND or DECRYPT): abort immediately; the stored key is invalid.

Test Plan:
- FIPS-197 C.3:
  - Apply rst=0, release, then load kt=000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f.
  - Wait for ct_rdy, then apply ct=8ea2b7ca516745bfeafc49904b496089.
  - Required: pt=00112233445566778899aabbccddeeff with a single-cycle pt_vld exactly 14 cycles after accept.
- SP800-38a F.1.6:
  - Load kt=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, then ct=f3eed1bdb5d2a03c064b5a7e3db181f8.
  - Required: pt=6bc1bee22e409f96e93d7e117393172a.
- Back-to-back:
  - Keep the FIPS key loaded. Apply the C.3 ct again, then the same ct again on the cycle ct_rdy returns.
  - Required: both results equal 00112233445566778899aabbccddeeff, with no key reload.
- Handshake:
  - Pulse ct_vld during EXPAND and during DECRYPT: no extra pt_vld occurs.
  - Measure kt_rdy low for 52 cycles after a key load.
  - Assert kt_vld and ct_vld together in IDLE_KEY: ct is dropped.
- Reset mid-decrypt:
  - Assert rst=0 at DECRYPT round 7.
  - Required: pt=0, pt_vld=0, ct_rdy=0, kt_rdy=1; a subsequent reload of the C.3 key and ct decrypts correctly.
- Random: 1000 random key/ct pairs compared against the behavioural AES-256 model.

Source files
------------

// File: rtl/aes256_decrypt_core_if.sv
// aes256_decrypt_core_if: key, ciphertext and plaintext block handshakes of the AES-256 decryptor
interface aes256_decrypt_core_if;
  logic [0:255] kt;
  logic         kt_vld;
  logic         kt_rdy;
  logic [0:127] ct;
  logic         ct_vld;
  logic         ct_rdy;
  logic [0:127] pt;
  logic         pt_vld;
  modport master (output kt, kt_vld, ct, ct_vld, input kt_rdy, ct_rdy, pt, pt_vld);
  modport slave (input kt, kt_vld, ct, ct_vld, output kt_rdy, ct_rdy, pt, pt_vld);
endinterface

// File: rtl/aes256_decrypt_core.sv
// aes256_decrypt_core: iterative AES-256 inverse cipher, one round per clock, on-chip key expansion
module aes256_decrypt_core (
  input logic                  clk,
  input logic                  rst,
  aes256_decrypt_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE_NOKEY, EXPAND, IDLE_KEY, DECRYPT} state_e;
  state_e       state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [5:0]   i_q, i_d;
  logic [0:127] st_q, st_d, pt_q, pt_d;
  logic         pt_vld_q, pt_vld_d;
  logic [31:0]  w_q [60];
  logic         key_ld, w_we;
  logic [3:0]   rk_sel;
  logic [0:127] rk, rnd, rnd_out;
  logic [31:0]  wm1, wm8, w_new;
  logic [7:0]   rcon;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction
  function automatic logic [0:127] inv_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[32*c + 8*r +: 8] = s[32*((c - r + 4) % 4) + 8*r +: 8];
    return o;
  endfunction
  function automatic logic [0:127] inv_sub(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction
  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [0:127] o;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], s[32*c + 8*k +: 8]);
        o[32*c + 8*r +: 8] = acc;
      end
    return o;
  endfunction
  assign rk_sel  = (state_q == DECRYPT) ? r_q : 4'd14;
  assign rk      = {w_q[{rk_sel, 2'b00}], w_q[{rk_sel, 2'b01}], w_q[{rk_sel, 2'b10}], w_q[{rk_sel, 2'b11}]};
  assign rnd     = inv_sub(inv_shift(st_q)) ^ rk;
  assign rnd_out = (r_q == 4'd0) ? rnd : inv_mix(rnd);
  assign wm1     = w_q[i_q - 6'd1];
  assign wm8     = w_q[i_q - 6'd8];
  assign rcon    = 8'h01 << (i_q[5:3] - 3'd1);
  assign w_new   = wm8 ^ ((i_q[2:0] == 3'd0) ? sub_word({wm1[23:0], wm1[31:24]}) ^ {rcon, 24'h0}
                        : (i_q[2:0] == 3'd4) ? sub_word(wm1) : wm1);
  assign bus.kt_rdy = (state_q == IDLE_NOKEY) || (state_q == IDLE_KEY);
  assign bus.ct_rdy = (state_q == IDLE_KEY);
  assign bus.pt     = pt_q;
  assign bus.pt_vld = pt_vld_q;
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    i_d      = i_q;
    st_d     = st_q;
    pt_d     = pt_q;
    pt_vld_d = 1'b0;
    key_ld   = 1'b0;
    w_we     = 1'b0;
    case (state_q)
      IDLE_NOKEY, IDLE_KEY: begin
        if (bus.kt_vld) begin
          key_ld  = 1'b1;
          i_d     = 6'd8;
          state_d = EXPAND;
        end else if (state_q == IDLE_KEY && bus.ct_vld) begin
          st_d    = bus.ct ^ rk;
          r_d     = 4'd13;
          state_d = DECRYPT;
        end
      end
      EXPAND: begin
        w_we    = 1'b1;
        i_d     = i_q + 6'd1;
        state_d = (i_q == 6'd59) ? IDLE_KEY : EXPAND;
      end
      DECRYPT: begin
        st_d = rnd_out;
        r_d  = r_q - 4'd1;
        if (r_q == 4'd0) begin
          pt_d     = rnd_out;
          pt_vld_d = 1'b1;
          state_d  = IDLE_KEY;
        end
      end
      default: state_d = IDLE_NOKEY;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE_NOKEY;
      r_q      <= 4'd0;
      i_q      <= 6'd8;
      st_q     <= '0;
      pt_q     <= '0;
      pt_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      i_q      <= i_d;
      st_q     <= st_d;
      pt_q     <= pt_d;
      pt_vld_q <= pt_vld_d;
    end
  // round-key store is not reset: only the FSM decides whether its contents are valid
  always_ff @(posedge clk)
    if (key_ld) begin
      for (int k = 0; k < 8; k++) w_q[k] <= bus.kt[32*k +: 32];
    end else if (w_we) begin
      w_q[i_q] <= w_new;
    end
endmodule

// File: tb/tb_aes256_decrypt_core.sv
// tb_aes256_decrypt_core: known-answer vectors, handshake corners and random pairs against a forward-cipher model
module tb_aes256_decrypt_core;
  typedef struct {
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  bit           clk;
  logic         rst;
  int           n_cmp, n_err, cyc;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [7:0]   sb [256];
  vec_t         vecs [2];
  aes256_decrypt_core_if bus ();
  aes256_decrypt_core dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  always @(posedge clk)
    if (rst && bus.ct_vld && bus.ct_rdy && !bus.kt_vld) acc_q.push_back(cyc + 1);
  always @(negedge clk)
    if (rst && bus.pt_vld) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pt_vld: got pt=%h with nothing outstanding", bus.pt);
      end else begin
        logic [127:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("pt", 256'(bus.pt), 256'(e));
        chk("latency", 256'(cyc - a), 256'(14));
      end
    end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  task automatic init_sbox();
    logic [7:0] inv, o, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        o[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^ inv[(b + 7) % 8] ^ c[b];
      sb[x] = o;
    end
  endtask
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction
  function automatic logic [127:0] aes_enc(input logic [255:0] key, input logic [127:0] p);
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) tmp = subw(tmp);
      w[i] = w[i-8] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = p[127 - 8*k -: 8] ^ w[k/4][31 - 8*(k%4) -: 8];
    for (int rd = 1; rd <= 14; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rd < 14) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r + 4*c] = xt(s[r + 4*c]) ^ xt(s[(r+1)%4 + 4*c]) ^ s[(r+1)%4 + 4*c]
                       ^ s[(r+2)%4 + 4*c] ^ s[(r+3)%4 + 4*c];
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rd + k/4][31 - 8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = s[k];
    return o;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic expand_wait(input bit pulse);
    int n;
    bit saw_ct;
    n = 0;
    saw_ct = 0;
    @(negedge clk);
    while (!bus.kt_rdy && n < 200) begin
      if (bus.ct_rdy) saw_ct = 1;
      bus.ct_vld = pulse && (n < 10);
      bus.ct = rnd128();
      n++;
      @(negedge clk);
    end
    bus.ct_vld = 1'b0;
    chk("kt_rdy_low_cycles", 256'(n), 256'(52));
    chk("ct_rdy_during_expand", 256'(saw_ct), 256'(0));
  endtask
  task automatic load_key(input logic [255:0] k, input bit pulse);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.kt_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("kt_rdy_wait", 256'(bus.kt_rdy), 256'(1));
    bus.kt = k;
    bus.kt_vld = 1'b1;
    @(posedge clk);
    #1 bus.kt_vld = 1'b0;
    expand_wait(pulse);
  endtask
  task automatic send_ct(input logic [127:0] c, input logic [127:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.ct_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.ct_rdy) chk("ct_rdy_wait", 256'(bus.ct_rdy), 256'(1));
    else begin
      bus.ct = c;
      bus.ct_vld = 1'b1;
      exp_q.push_back(p);
      @(posedge clk);
      #1 bus.ct_vld = 1'b0;
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 256'(exp_q.size()), 256'(0));
  endtask
  initial begin
    rst = 1'b1;
    bus.kt = '0;
    bus.kt_vld = 1'b0;
    bus.ct = '0;
    bus.ct_vld = 1'b0;
    vecs[0] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                ct: 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, pt: 128'h6bc1bee22e409f96e93d7e117393172a};
    init_sbox();
    #1 rst = 1'b0;
    #1;
    chk("reset_pt", 256'(bus.pt), 256'(0));
    chk("reset_pt_vld", 256'(bus.pt_vld), 256'(0));
    chk("reset_kt_rdy", 256'(bus.kt_rdy), 256'(1));
    chk("reset_ct_rdy", 256'(bus.ct_rdy), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int v = 0; v < 2; v++) begin
      chk("model_kat", 256'(aes_enc(vecs[v].key, vecs[v].pt)), 256'(vecs[v].ct));
      load_key(vecs[v].key, 1'b0);
      send_ct(vecs[v].ct, vecs[v].pt);
      drain();
      @(negedge clk);
      chk("pt_hold", 256'(bus.pt), 256'(vecs[v].pt));
    end
    // ciphertext pulses during expansion, then two blocks back-to-back on the same key
    load_key(vecs[0].key, 1'b1);
    send_ct(vecs[0].ct, vecs[0].pt);
    send_ct(vecs[0].ct, vecs[0].pt);
    drain();
    send_ct(vecs[0].ct, vecs[0].pt);
    repeat (5) begin
      @(negedge clk);
      bus.ct_vld = 1'b1;
      bus.ct = rnd128();
    end
    @(negedge clk);
    bus.ct_vld = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    // key and ciphertext together: the key must win
    @(negedge clk);
    chk("collision_ct_rdy", 256'(bus.ct_rdy), 256'(1));
    bus.kt = vecs[1].key;
    bus.kt_vld = 1'b1;
    bus.ct = vecs[0].ct;
    bus.ct_vld = 1'b1;
    @(posedge clk);
    #1;
    bus.kt_vld = 1'b0;
    bus.ct_vld = 1'b0;
    expand_wait(1'b0);
    repeat (20) @(negedge clk);
    send_ct(vecs[1].ct, vecs[1].pt);
    drain();
    // reset while the round counter sits at 7
    load_key(vecs[0].key, 1'b0);
    send_ct(vecs[0].ct, vecs[0].pt);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("midrst_pt", 256'(bus.pt), 256'(0));
    chk("midrst_pt_vld", 256'(bus.pt_vld), 256'(0));
    chk("midrst_ct_rdy", 256'(bus.ct_rdy), 256'(0));
    chk("midrst_kt_rdy", 256'(bus.kt_rdy), 256'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("postrst_ct_rdy", 256'(bus.ct_rdy), 256'(0));
    load_key(vecs[0].key, 1'b0);
    send_ct(vecs[0].ct, vecs[0].pt);
    drain();
    for (int k = 0; k < 250; k++) begin
      logic [255:0] key;
      key = {rnd128(), rnd128()};
      load_key(key, 1'b0);
      for (int j = 0; j < 4; j++) begin
        logic [127:0] p;
        p = rnd128();
        send_ct(aes_enc(key, p), p);
      end
    end
    drain();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
